// File: rtl/sipo_buf_drain.sv
// Readout controller for the SIPO capture buffer: rewinds the buffer address,
// reads the requested words in order and streams them out on valid/ready.
module sipo_buf_drain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [6:0]       nwords,
    output logic             busy,
    output logic             done,
    output logic             buf_addrclr,
    output logic             buf_cnten,
    output logic             buf_ren,
    input  logic [WIDTH-1:0] buf_dout,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [2:0]       dbg_state
);

    // Stream handshake: a word transfers on a rising edge where m_valid and
    // m_ready are both high; m_valid never waits on m_ready and m_data is held
    // stable while m_valid is high and m_ready is low.

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_READ  = 3'd2,
        ST_CAP   = 3'd3,
        ST_VALID = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [6:0] LP_DEPTH = 7'(DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [6:0]       r_remaining;
    logic [WIDTH-1:0] r_m_data;
    logic [6:0]       w_nwords_clamped;
    logic             w_start_ok;
    logic             w_handshake;

    assign w_nwords_clamped = (nwords > LP_DEPTH) ? LP_DEPTH : nwords;
    assign w_start_ok       = (r_state == ST_IDLE) && start && !abort;
    assign w_handshake      = (r_state == ST_VALID) && m_ready && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (abort && (r_state != ST_IDLE)) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        w_next = (nwords == 7'd0) ? ST_DONE : ST_CLR;
                    end
                end
                ST_CLR:   w_next = ST_READ;
                ST_READ:  w_next = ST_CAP;
                ST_CAP:   w_next = ST_VALID;
                ST_VALID: begin
                    if (m_ready) begin
                        w_next = (r_remaining == 7'd1) ? ST_DONE : ST_READ;
                    end
                end
                ST_DONE:  w_next = ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        buf_addrclr = (r_state == ST_CLR);
        buf_ren     = (r_state == ST_READ);
        buf_cnten   = (r_state == ST_CAP);
        m_valid     = (r_state == ST_VALID);
        m_data      = r_m_data;
        dbg_state   = r_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_remaining <= 7'd0;
        end else if (w_start_ok && (nwords != 7'd0)) begin
            r_remaining <= w_nwords_clamped;
        end else if (w_handshake) begin
            r_remaining <= r_remaining - 7'd1;
        end
    end

    // Buffer read data is valid during CAP, one cycle after the READ strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_data <= '0;
        end else if ((r_state == ST_CAP) && !abort) begin
            r_m_data <= buf_dout;
        end
    end

endmodule
